// File: rtl/mac_tcdm_rr_arbiter.sv
// mac_tcdm_rr_arbiter
//   Shares one TCDM master port among N_REQ requesters with round-robin priority.
//   A request stalled by the TCDM (out_req_o=1, out_gnt_i=0) locks the winner until it
//   is granted. Granted requester indices are queued in an outstanding FIFO so that
//   in-order responses can be steered back to the right requester.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   in_req_i / in_gnt_o   per-requester request / zero-cycle grant
//   in_add_i, in_wen_i,   per-requester address, write-enable (1=read), byte enables,
//   in_be_i, in_data_i    write data
//   in_r_data_o           response data shared by all requesters
//   in_r_valid_o          one-hot response strobe
//   out_*                 TCDM master request port and response inputs
//   err_o                 sticky: response arrived with nothing outstanding
//
// Optional build macro
//   MAC_TCDM_ARB_STATS_EN adds stat_clear_i, stat_grant_cnt_o and stat_stall_cnt_o
//   (saturating 32-bit counters).
module mac_tcdm_rr_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned OUTST_DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [N_REQ-1:0]       in_req_i,
    output logic [N_REQ-1:0]       in_gnt_o,
    input  logic [N_REQ-1:0][31:0] in_add_i,
    input  logic [N_REQ-1:0]       in_wen_i,
    input  logic [N_REQ-1:0][3:0]  in_be_i,
    input  logic [N_REQ-1:0][31:0] in_data_i,
    output logic [31:0]            in_r_data_o,
    output logic [N_REQ-1:0]       in_r_valid_o,
    output logic                   out_req_o,
    input  logic                   out_gnt_i,
    output logic [31:0]            out_add_o,
    output logic                   out_wen_o,
    output logic [3:0]             out_be_o,
    output logic [31:0]            out_data_o,
    input  logic [31:0]            out_r_data_i,
    input  logic                   out_r_valid_i,
    output logic                   err_o
`ifdef MAC_TCDM_ARB_STATS_EN
    ,
    input  logic                   stat_clear_i,
    output logic [31:0]            stat_grant_cnt_o,
    output logic [31:0]            stat_stall_cnt_o
`endif
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned PTR_W = $clog2(OUTST_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {StIdle, StLocked} state_e;

    state_e             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_rr_ptr, r_lock_idx;
    logic [IDX_W-1:0]   w_cand, w_rr_idx, w_win_idx, w_rr_nxt;
    logic               w_rr_found, w_win_valid;
    logic               w_full, w_empty, w_grant, w_pop;
    logic [IDX_W-1:0]   r_fifo_mem [OUTST_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_err;

    // First active requester at or after r_rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        w_cand     = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            w_cand = IDX_W'((32'(r_rr_ptr) + k) % N_REQ);
            if (!w_rr_found && in_req_i[w_cand]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_cand;
            end
        end
    end

    // A locked winner is held even if other requests change.
    assign w_win_valid = (r_state == StLocked) || w_rr_found;
    assign w_win_idx   = (r_state == StLocked) ? r_lock_idx : w_rr_idx;

    assign w_full    = (r_count == CNT_W'(OUTST_DEPTH));
    assign w_empty   = (r_count == '0);
    assign out_req_o = w_win_valid && !w_full;
    assign w_grant   = out_req_o && out_gnt_i;
    assign w_pop     = out_r_valid_i && !w_empty;
    assign w_rr_nxt  = (w_win_idx == IDX_W'(N_REQ - 1)) ? '0 : w_win_idx + IDX_W'(1);

    assign in_r_data_o = out_r_data_i;
    assign err_o       = r_err;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle:   if (out_req_o && !out_gnt_i) w_state_nxt = StLocked;
            StLocked: if (out_gnt_i) w_state_nxt = StIdle;
            default:  w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        in_gnt_o     = '0;
        in_r_valid_o = '0;
        out_add_o    = '0;
        out_wen_o    = 1'b0;
        out_be_o     = '0;
        out_data_o   = '0;
        if (w_grant) in_gnt_o[w_win_idx] = 1'b1;
        if (w_pop)   in_r_valid_o[r_fifo_mem[r_rd_ptr]] = 1'b1;
        if (w_win_valid) begin
            out_add_o  = in_add_i[w_win_idx];
            out_wen_o  = in_wen_i[w_win_idx];
            out_be_o   = in_be_i[w_win_idx];
            out_data_o = in_data_i[w_win_idx];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= StIdle;
            r_lock_idx <= '0;
            r_rr_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == StIdle && out_req_o && !out_gnt_i) r_lock_idx <= w_rr_idx;
            if (w_grant) begin
                r_rr_ptr <= w_rr_nxt;
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            // Simultaneous push and pop leaves occupancy unchanged.
            if (w_grant && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_grant) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (out_r_valid_i && w_empty) r_err <= 1'b1;
        end
    end

    // Storage needs no reset: entries are only read while the FIFO is non-empty.
    always_ff @(posedge clk_i) begin
        if (w_grant) r_fifo_mem[r_wr_ptr] <= w_win_idx;
    end

`ifdef MAC_TCDM_ARB_STATS_EN
    logic        w_stall;
    logic [31:0] r_grant_cnt, r_stall_cnt;

    // Stalled by the TCDM, or a winner held off by a full FIFO.
    assign w_stall = (out_req_o && !out_gnt_i) || (w_win_valid && w_full);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_grant_cnt <= '0;
            r_stall_cnt <= '0;
        end else if (stat_clear_i) begin
            r_grant_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_grant && (r_grant_cnt != '1)) r_grant_cnt <= r_grant_cnt + 32'd1;
            if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stat_grant_cnt_o = r_grant_cnt;
    assign stat_stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_mac_tcdm_rr_arbiter.sv
// tb_mac_tcdm_rr_arbiter
//   Directed stimulus for mac_tcdm_rr_arbiter (N_REQ=4, OUTST_DEPTH=4). A queue-based
//   reference model is compared against every DUT output on each falling edge, and
//   directed scenarios add hand-computed literal expectations.
module tb_mac_tcdm_rr_arbiter;

    localparam int N = 4;
    localparam int D = 4;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [N-1:0]      in_req_i;
    logic [N-1:0]      in_gnt_o;
    logic [N-1:0][31:0] in_add_i;
    logic [N-1:0]      in_wen_i;
    logic [N-1:0][3:0] in_be_i;
    logic [N-1:0][31:0] in_data_i;
    logic [31:0]       in_r_data_o;
    logic [N-1:0]      in_r_valid_o;
    logic              out_req_o;
    logic              out_gnt_i;
    logic [31:0]       out_add_o;
    logic              out_wen_o;
    logic [3:0]        out_be_o;
    logic [31:0]       out_data_o;
    logic [31:0]       out_r_data_i;
    logic              out_r_valid_i;
    logic              err_o;

    mac_tcdm_rr_arbiter #(
        .N_REQ       (N),
        .OUTST_DEPTH (D)
    ) u_dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .in_req_i      (in_req_i),
        .in_gnt_o      (in_gnt_o),
        .in_add_i      (in_add_i),
        .in_wen_i      (in_wen_i),
        .in_be_i       (in_be_i),
        .in_data_i     (in_data_i),
        .in_r_data_o   (in_r_data_o),
        .in_r_valid_o  (in_r_valid_o),
        .out_req_o     (out_req_o),
        .out_gnt_i     (out_gnt_i),
        .out_add_o     (out_add_o),
        .out_wen_o     (out_wen_o),
        .out_be_o      (out_be_o),
        .out_data_o    (out_data_o),
        .out_r_data_i  (out_r_data_i),
        .out_r_valid_i (out_r_valid_i),
        .err_o         (err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Reference model: outstanding requesters in grant order, next-priority index,
    // pending (stalled) winner and sticky error.
    int q_outst[$];
    int m_rr     = 0;
    bit m_locked = 1'b0;
    int m_lidx   = 0;
    bit m_err    = 1'b0;

    always @(negedge clk_i) begin : model_chk
        int       w;
        bit       found;
        bit       ereq;
        bit       pop;
        logic [3:0] egnt;
        logic [3:0] erv;
        if (rst_i) begin
            q_outst.delete();
            m_rr     = 0;
            m_locked = 1'b0;
            m_err    = 1'b0;
        end
        found = 1'b0;
        w     = 0;
        if (m_locked) begin
            found = 1'b1;
            w     = m_lidx;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!found && in_req_i[(m_rr + k) % N]) begin
                    found = 1'b1;
                    w     = (m_rr + k) % N;
                end
            end
        end
        ereq = found && (q_outst.size() < D);
        egnt = (ereq && out_gnt_i) ? 4'(1 << w) : 4'h0;
        pop  = out_r_valid_i && (q_outst.size() > 0);
        erv  = pop ? 4'(1 << q_outst[0]) : 4'h0;

        chk("m_out_req",  32'(out_req_o), 32'(ereq));
        chk("m_in_gnt",   32'(in_gnt_o), 32'(egnt));
        chk("m_out_add",  out_add_o,  found ? in_add_i[w] : 32'h0);
        chk("m_out_wen",  32'(out_wen_o), found ? 32'(in_wen_i[w]) : 32'h0);
        chk("m_out_be",   32'(out_be_o),  found ? 32'(in_be_i[w]) : 32'h0);
        chk("m_out_data", out_data_o, found ? in_data_i[w] : 32'h0);
        chk("m_r_valid",  32'(in_r_valid_o), 32'(erv));
        chk("m_r_data",   in_r_data_o, out_r_data_i);
        chk("m_err",      32'(err_o), 32'(m_err));

        if (!rst_i) begin
            if (out_r_valid_i && q_outst.size() == 0) m_err = 1'b1;
            if (pop) void'(q_outst.pop_front());
            if (ereq && out_gnt_i) begin
                q_outst.push_back(w);
                m_rr     = (w + 1) % N;
                m_locked = 1'b0;
            end else if (ereq) begin
                m_locked = 1'b1;
                m_lidx   = w;
            end
        end
    end

    logic [3:0] g_rr  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] rv_rr [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [3:0] g_full[4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        rst_i         = 1'b1;
        in_req_i      = '0;
        out_gnt_i     = 1'b0;
        out_r_valid_i = 1'b0;
        out_r_data_i  = '0;
        for (int i = 0; i < N; i++) begin
            in_add_i[i]  = 32'h1000 + 32'(i * 4);
            in_wen_i[i]  = 1'(i & 1);
            in_be_i[i]   = 4'(1 << i);
            in_data_i[i] = 32'hC0DE0000 + 32'(i);
        end

        // Reset state
        @(negedge clk_i);
        chk("rst_err",    32'(err_o), 32'h0);
        chk("rst_rvalid", 32'(in_r_valid_o), 32'h0);
        chk("rst_req",    32'(out_req_o), 32'h0);
        step();
        rst_i = 1'b0;

        // All requesting, always granted, 1-cycle responses
        in_req_i  = '1;
        out_gnt_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            out_r_valid_i = (c > 0);
            out_r_data_i  = 32'hA5A50000 + 32'(c);
            @(negedge clk_i);
            chk("rr_gnt",    32'(in_gnt_o), 32'(g_rr[c]));
            chk("rr_rvalid", 32'(in_r_valid_o), 32'(rv_rr[c]));
            step();
        end
        in_req_i = '0;
        @(negedge clk_i);
        chk("rr_rvalid_last", 32'(in_r_valid_o), 32'h1);
        chk("rr_rdata_last",  in_r_data_o, 32'hA5A50004);
        step();
        out_r_valid_i = 1'b0;

        // Stalled request 2 stays locked while request 0 arrives
        in_req_i  = 4'b0100;
        out_gnt_i = 1'b0;
        @(negedge clk_i);
        chk("lock_add_c1", out_add_o, 32'h1008);
        step();
        in_req_i = 4'b0101;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_i);
            chk("lock_add_held", out_add_o, 32'h1008);
            chk("lock_no_gnt",   32'(in_gnt_o), 32'h0);
            step();
        end
        out_gnt_i = 1'b1;
        @(negedge clk_i);
        chk("lock_gnt2", 32'(in_gnt_o), 32'b0100);
        step();
        in_req_i = 4'b0001;
        @(negedge clk_i);
        chk("after_lock_gnt0", 32'(in_gnt_o), 32'b0001);
        step();
        in_req_i      = '0;
        out_r_valid_i = 1'b1;
        @(negedge clk_i);
        chk("lock_rv2", 32'(in_r_valid_o), 32'b0100);
        step();
        @(negedge clk_i);
        chk("lock_rv0", 32'(in_r_valid_o), 32'b0001);
        step();
        out_r_valid_i = 1'b0;

        // FIFO fills after four grants; one response frees one slot
        in_req_i = '1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            chk("fill_gnt", 32'(in_gnt_o), 32'(g_full[c]));
            step();
        end
        @(negedge clk_i);
        chk("full_noreq", 32'(out_req_o), 32'h0);
        chk("full_nognt", 32'(in_gnt_o), 32'h0);
        step();
        out_r_valid_i = 1'b1;
        @(negedge clk_i);
        chk("full_pop_rv",    32'(in_r_valid_o), 32'b0010);
        chk("full_pop_noreq", 32'(out_req_o), 32'h0);
        step();
        out_r_valid_i = 1'b0;
        @(negedge clk_i);
        chk("refill_gnt", 32'(in_gnt_o), 32'b0010);
        step();

        // Drain, then grant and response in the same cycle
        in_req_i      = '0;
        out_r_valid_i = 1'b1;
        for (int c = 0; c < 4; c++) step();
        out_r_valid_i = 1'b0;
        in_req_i      = 4'b1000;
        @(negedge clk_i);
        chk("sim_pre_gnt3", 32'(in_gnt_o), 32'b1000);
        step();
        in_req_i      = 4'b0010;
        out_r_valid_i = 1'b1;
        @(negedge clk_i);
        chk("sim_gnt1", 32'(in_gnt_o), 32'b0010);
        chk("sim_rv3",  32'(in_r_valid_o), 32'b1000);
        step();
        in_req_i = '0;
        @(negedge clk_i);
        chk("sim_later_rv1", 32'(in_r_valid_o), 32'b0010);
        step();

        // Response with nothing outstanding
        @(negedge clk_i);
        chk("err_rv_zero", 32'(in_r_valid_o), 32'h0);
        chk("err_before",  32'(err_o), 32'h0);
        step();
        out_r_valid_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            chk("err_sticky", 32'(err_o), 32'h1);
            step();
        end

        // Reset with two outstanding
        in_req_i = 4'b1100;
        step();
        step();
        in_req_i = '0;
        rst_i    = 1'b1;
        @(negedge clk_i);
        chk("rst_err_clr", 32'(err_o), 32'h0);
        chk("rst_req_clr", 32'(out_req_o), 32'h0);
        step();
        rst_i         = 1'b0;
        out_r_valid_i = 1'b1;
        @(negedge clk_i);
        chk("late_rv_zero", 32'(in_r_valid_o), 32'h0);
        step();
        out_r_valid_i = 1'b0;
        in_req_i      = 4'b1010;
        @(negedge clk_i);
        chk("late_err",     32'(err_o), 32'h1);
        chk("post_rst_gnt", 32'(in_gnt_o), 32'b0010);
        step();
        in_req_i      = '0;
        out_r_valid_i = 1'b1;
        @(negedge clk_i);
        chk("post_rst_rv", 32'(in_r_valid_o), 32'b0010);
        step();
        out_r_valid_i = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/mac_tcdm_rr_arbiter.md
MAC_TCDM_RR_ARBITER -- requirements
Module: mac_tcdm_rr_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requester ports (2..8).
REQ-002 SHALL have parameter OUTST_DEPTH, default 4: maximum granted transactions awaiting response (power of two, 2..16).
REQ-003 SHALL have port clk_i  in  1  sole clock, all state rising-edge.
REQ-004 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports in_req_i in N_REQ / in_gnt_o out N_REQ: per-requester request and grant.
REQ-006 SHALL have ports in_add_i in N_REQ×32 / in_wen_i in N_REQ (1=read, 0=write) / in_be_i in N_REQ×4 / in_data_i in N_REQ×32.
REQ-007 SHALL have ports in_r_data_o out 32 (shared by all requesters) / in_r_valid_o out N_REQ (one-hot response strobe).
REQ-008 SHALL have ports out_req_o out 1 / out_gnt_i in 1 / out_add_o out 32 / out_wen_o out 1 / out_be_o out 4 / out_data_o out 32: single TCDM master port.
REQ-009 SHALL have ports out_r_data_i in 32 / out_r_valid_i in 1: TCDM response.
REQ-010 SHALL have port err_o  out  1  sticky flag, response received with no outstanding transaction.

Function
REQ-011 SHALL share one TCDM master port among N_REQ requesters by round-robin; priority starts at index rr_ptr and wraps modulo N_REQ.
REQ-012 SHALL implement FSM IDLE/LOCKED: IDLE -> LOCKED when out_req_o=1 and out_gnt_i=0; LOCKED -> IDLE on out_gnt_i=1.
REQ-013 In IDLE the winner SHALL be selected combinationally; in LOCKED the winner registered on entry SHALL be held regardless of other in_req_i changes (no preemption of a pending request).
REQ-014 out_req_o SHALL be 1 iff a winner exists and the outstanding FIFO is not full; out_add/wen/be/data SHALL mux the winner's fields (zero when no winner).
REQ-015 in_gnt_o[w] SHALL equal out_req_o & out_gnt_i for winner w, zero for all others; grant path is zero-cycle combinational.
REQ-016 On grant, rr_ptr SHALL become (w+1) mod N_REQ and index w SHALL be pushed into the outstanding FIFO.
REQ-017 On out_r_valid_i with FIFO non-empty, in_r_valid_o SHALL be one-hot at the FIFO head index in the same cycle, the head SHALL pop, and in_r_data_o SHALL equal out_r_data_i; responses return in grant order.
REQ-018 Every granted transaction, read or write, SHALL consume exactly one response.
REQ-019 Simultaneous grant and response SHALL push and pop in the same cycle; occupancy is unchanged.
REQ-020 FIFO full SHALL force out_req_o=0 (FSM stays IDLE) until a pop; a full FIFO with simultaneous pop SHALL NOT grant in that cycle.
REQ-021 out_r_valid_i with FIFO empty SHALL drive in_r_valid_o=0 and set err_o until reset.
REQ-022 in_req_i deasserted by the locked winner before grant is a protocol violation; behaviour is undefined and not checked.

Reset
REQ-023 rst_i=1 SHALL asynchronously force FSM=IDLE, rr_ptr=0, FIFO empty, err_o=0; outputs then follow REQ-014/015/017 with an empty FIFO (in_r_valid_o=0).
REQ-024 Reset mid-transaction SHALL discard outstanding entries; late responses after reset set err_o.

Configuration
REQ-025 With MAC_TCDM_ARB_STATS_EN defined, the block SHALL add input stat_clear_i (1) and outputs stat_grant_cnt_o (32, grants) and stat_stall_cnt_o (32, cycles with out_req_o=1 & out_gnt_i=0 or with a winner blocked by full FIFO), saturating, cleared by reset or stat_clear_i.
REQ-026 Without MAC_TCDM_ARB_STATS_EN those ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-027 N_REQ=4, all in_req_i=1, out_gnt_i=1, 1-cycle response -> grants to 0,1,2,3,0 on consecutive cycles, in_r_valid_o one cycle later in the same order.
REQ-028 Req 2 asserted, out_gnt_i=0 for 3 cycles, req 0 asserted in cycle 1 -> out_add_o stays req 2's, in_gnt_o[2] on cycle 4, req 0 granted the next cycle.
REQ-029 OUTST_DEPTH=4, out_gnt_i=1, no responses -> 4 grants, then out_req_o=0; one response -> one further grant in the next cycle.
REQ-030 Grant of req 1 and response for req 3 in the same cycle -> in_r_valid_o=4'b1000, occupancy unchanged, later response goes to req 1.
REQ-031 out_r_valid_i pulse with FIFO empty -> in_r_valid_o=0, err_o=1 held until rst_i.
REQ-032 rst_i pulsed with 2 outstanding -> rr_ptr=0, FIFO empty; first request granted is lowest-index active requester.
